// File: rtl/cell_tester_pkg.sv
// Shared types and index helpers for the standard-cell sweep tester.
package cell_tester_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  function automatic int clamp_n_in(input int n, input int max_n);
    return (n > max_n) ? max_n : n;
  endfunction

  function automatic int in_lsb(input int ch, input int n_in);
    return ch * n_in;
  endfunction

  function automatic int out_lsb(input int ch, input int n_out);
    return ch * n_out;
  endfunction

  function automatic int tt_lsb(input int v, input int n_out);
    return v * n_out;
  endfunction

endpackage

// File: rtl/cell_tester_cmp.sv
// Masked compare of one sampled CUT output against its truth-table entry;
// keeps the saturating error count, first failing vector and pass flag.
module cell_tester_cmp
  import cell_tester_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample,
  input  logic             last,
  input  logic [N_OUT-1:0] obs,
  input  logic [N_OUT-1:0] exp_v,
  input  logic [N_OUT-1:0] mask,
  input  logic [N_IN-1:0]  vec,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec,
  output logic             pass
);

  logic mismatch;

  assign mismatch = |((obs ^ exp_v) & mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      pass       <= 1'b0;
    end else if (clear) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      pass       <= 1'b0;
    end else if (sample) begin
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= vec;
        end
      end
      // Saturation never returns to zero, so the pre-update count is enough here.
      if (last) pass <= (err_cnt == '0) && !mismatch;
    end
  end

endmodule

// File: rtl/cell_sweep_tester.sv
// Exhaustive input sweep of one selected cell channel; each vector takes SETTLE+2
// cycles (apply, settle, sample), done pulses V*(SETTLE+2)+1 cycles after start.
module cell_sweep_tester
  import cell_tester_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 4,
  parameter int ERR_W  = 8,
  localparam int CH_W  = $clog2(N_CH),
  localparam int NI_W  = $clog2(N_IN + 1),
  localparam int ST_W  = $clog2(SETTLE + 1),
  localparam int TT_W  = (2 ** N_IN) * N_OUT
) (
  input  logic                    wb_clk_i,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CH_W-1:0]         ch_sel,
  input  logic [NI_W-1:0]         n_in,
  input  logic [N_OUT-1:0]        out_mask,
  input  logic [TT_W-1:0]         expected,
  output logic [N_CH*N_IN-1:0]    cut_in,
  input  logic [N_CH*N_OUT-1:0]   cut_out,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [ERR_W-1:0]        err_cnt,
  output logic                    fail_valid,
  output logic [N_IN-1:0]         fail_vec
);

  state_t             state;
  logic [CH_W-1:0]    ch_q;
  logic [NI_W-1:0]    n_in_q;
  logic [N_OUT-1:0]   mask_q;
  logic [TT_W-1:0]    exp_q;
  logic [N_IN-1:0]    vec;
  logic [ST_W-1:0]    st_cnt;
  logic [N_IN:0]      v_lim;
  logic               last_vec;
  logic               sample_en;
  logic               clear;
  logic [N_OUT-1:0]   obs;
  logic [N_OUT-1:0]   exp_v;

  assign v_lim     = {{N_IN{1'b0}}, 1'b1} << n_in_q;
  assign last_vec  = ({1'b0, vec} == (v_lim - 1'b1));
  assign sample_en = (state == S_SAMPLE);
  assign clear     = (state == S_IDLE) && start;
  assign obs       = cut_out[out_lsb(int'(ch_q), N_OUT) +: N_OUT];
  assign exp_v     = exp_q[tt_lsb(int'(vec), N_OUT) +: N_OUT];

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ch_q   <= '0;
      n_in_q <= '0;
      mask_q <= '0;
      exp_q  <= '0;
      vec    <= '0;
      st_cnt <= '0;
      cut_in <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ch_q   <= ch_sel;
            n_in_q <= NI_W'(clamp_n_in(int'(n_in), N_IN));
            mask_q <= out_mask;
            exp_q  <= expected;
            vec    <= '0;
            cut_in <= '0;
            busy   <= 1'b1;
            state  <= S_APPLY;
          end
        end
        S_APPLY: begin
          st_cnt <= ST_W'(SETTLE - 1);
          state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (st_cnt == '0) state <= S_SAMPLE;
          else              st_cnt <= st_cnt - 1'b1;
        end
        S_SAMPLE: begin
          if (last_vec) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            // Next vector goes out on the same edge that re-enters APPLY.
            vec    <= vec + 1'b1;
            cut_in <= '0;
            cut_in[in_lsb(int'(ch_q), N_IN) +: N_IN] <= vec + 1'b1;
            state  <= S_APPLY;
          end
        end
        S_DONE: begin
          done   <= 1'b0;
          busy   <= 1'b0;
          cut_in <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  cell_tester_cmp #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT),
    .ERR_W (ERR_W)
  ) u_cmp (
    .clk        (wb_clk_i),
    .rst_n      (rst_n),
    .clear      (clear),
    .sample     (sample_en),
    .last       (last_vec),
    .obs        (obs),
    .exp_v      (exp_v),
    .mask       (mask_q),
    .vec        (vec),
    .err_cnt    (err_cnt),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec),
    .pass       (pass)
  );

endmodule

// File: doc/cell_sweep_tester.md
# cell_sweep_tester

Parametrised on-wafer exhaustive tester for the standard-cell test array. It drives every input combination into one selected cell-under-test (CUT) channel, waits a programmable settle time, then samples the CUT outputs. Each sample is compared against a truth table held by the controlling logic, and the block counts mismatches and records the first failing vector. It sits between the Caravel user-project control registers and the array of cell instances (AND2X1, AOI22X1, HAX1, INVX*, …).

## Interface
- N_CH, 8: number of CUT channels
- N_IN, 4: maximum inputs per cell (bit i drives pin A,B,C,D in order)
- N_OUT, 2: maximum outputs per cell (bit0 = Y/YS, bit1 = YC)
- SETTLE, 4: wait cycles between applying a vector and sampling it (≥1)
- ERR_W, 8: error-counter width
- wb_clk_i  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a sweep (level sampled; ignored while busy)
- ch_sel  in  $clog2(N_CH)  channel to test, latched at start
- n_in  in  $clog2(N_IN+1)  active inputs, latched at start; values >N_IN clamp to N_IN
- out_mask  in  N_OUT  outputs to compare, latched at start
- expect  in  (2**N_IN)*N_OUT  truth table; expect[v*N_OUT +: N_OUT] is the expected output for vector v; latched at start
- cut_in  out  N_CH*N_IN  registered drive to all channels
- cut_out  in  N_CH*N_OUT  CUT outputs
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- pass  out  1  err_cnt==0 for the last completed sweep
- err_cnt  out  ERR_W  mismatching vectors, saturating
- fail_valid  out  1  at least one mismatch in the last sweep
- fail_vec  out  N_IN  first failing vector

## Operation
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE, start=1:
  - latch ch_sel, n_in (clamped), out_mask and expect
  - clear err_cnt, fail_valid, fail_vec and pass
  - set vec=0 and go to APPLY
- APPLY: write vec (zero-extended) to the selected channel's slice of cut_in. All other slices are 0. Go to SETTLE.
- SETTLE: count SETTLE cycles, then go to SAMPLE.
- SAMPLE: mismatch = |((cut_out slice ^ expected[vec]) & out_mask).
  - On mismatch: err_cnt++ (saturates at all-ones). If fail_valid=0, capture fail_vec=vec and set fail_valid.
  - If vec == 2**n_in − 1, go to DONE; otherwise vec++ and go to APPLY.
- DONE: done=1 and pass=(err_cnt==0 after the final compare). Go to IDLE and drive cut_in to 0.
- Results (pass, err_cnt, fail_*) hold until the next accepted start.
- n_in=0 runs exactly one vector (all zeros).
- out_mask=0 means no compare can fail, so pass=1.
- Inputs bits ≥ n_in of the CUT drive 0.

## Timing
- Reset values:
  - state IDLE
  - cut_in 0, busy 0, done 0, pass 0
  - err_cnt 0, fail_valid 0, fail_vec 0
- busy is 1 in the cycle after the accepted start edge and stays 1 until done drops.
- Each vector costs SETTLE+2 cycles. With V=2**n_in, done pulses in cycle V*(SETTLE+2)+1 counted from the start edge.
- cut_in changes only on the edge that enters APPLY, or that leaves DONE.
- Sampling happens at the end of the SAMPLE cycle.
- start held high through DONE launches a new sweep from IDLE on the following edge. There are no back-to-back sweeps without an IDLE cycle.
- Asserting rst_n low mid-sweep clears everything immediately, including cut_in, and no done pulse is issued.

## Structure
- Package cell_tester_pkg holds:
  - the state enum
  - the clamp function for n_in
  - the per-channel slice index helpers
- One sub-module, cell_tester_cmp: masked compare, saturating err_cnt and first-fail capture. The FSM and vector/settle counters stay in cell_sweep_tester.

## Test plan
- AND2 model on ch 3, n_in=2, mask=01, expect=0x0040 (vector 3 → 1) → done at cycle 25, pass=1, err_cnt=0; cut_in nonzero only in bits 12–15.
- Same setup with a stuck-at-0 fault on Y → err_cnt=1, fail_vec=3, fail_valid=1, pass=0.
- HAX1 model, n_in=2, mask=11, fault with YC stuck at 1 → err_cnt=3, fail_vec=0. Repeat with mask=01 → pass=1.
- n_in=0, then n_in=7 (clamped to 4) → done at cycle 7 and at cycle 97 respectively.
- start pulsed again mid-sweep → ignored, and the done timing is unchanged. Force a 300-fail sweep at ERR_W=8 (large N_IN build) → err_cnt saturates at 255.
- rst_n asserted low during SETTLE of vector 2 → outputs return to reset values asynchronously and no done pulse. A fresh start after release runs a full sweep.
